control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: ROUNDS, default 4, number of cipher rounds, legal range 1..7.
REQ-002 Ports: clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 Ports: rst, input, 1, synchronous active-high reset.
REQ-004 Ports: cript_or_decript, input, 2, mode select: 2'b01 encrypt, 2'b10 decrypt, 2'b00/2'b11 invalid.
REQ-005 Ports: bgn, input, 1, start request, level-sensitive.
REQ-006 Ports: c0..c21, output, 1 each, one-hot datapath strobes.
- c0 = load key and data from bus.
- c1..c8 = encrypt path.
- c9..c18 = decrypt path.
- c19..c21 = output path.
REQ-007 Ports: counter_out, output, 3, current round count.

Function
REQ-008 FSM is Moore; each strobe is decoded from the state register only; at most one of c0..c21 is high in any cycle.
REQ-009 IDLE: no strobe high; at an edge with bgn=1 and a valid mode, the FSM latches the mode internally and moves to LOAD; invalid mode holds IDLE.
REQ-010 The latched mode governs the whole run; changes on cript_or_decript mid-run are ignored.
REQ-011 State sequence, one cycle per state:
- Encrypt: LOAD(c0) -> E_XOR(c1) -> round loop E_SAVE(c2), E_SUB(c3), E_SHIFT(c4), E_CNT(c5), E_MIX(c6), E_KSUB(c7), E_KADD(c8).
- Decrypt: LOAD(c0) -> D_XOR(c9) -> round loop D_SAVE(c10), D_SHIFT(c11), D_SUB(c12), D_CNT(c13), D_KSUB(c14), D_KADD(c15), D_IMIX(c16).
REQ-012 Round-loop exit, checked after E_KADD or D_IMIX:
- counter_out == ROUNDS: leave the loop.
- Otherwise: return to E_SAVE or D_SAVE.
REQ-013 Tails:
- Encrypt: E_OUT(c19) -> WR_DATA(c20) -> WR_KEY(c21) -> DONE.
- Decrypt: D_OUT(c17) -> D_FIN(c18) -> WR_DATA(c20) -> WR_KEY(c21) -> DONE.
REQ-014 DONE: no strobe high; return to IDLE at the first edge with bgn=0; a bgn held high does not restart a run.
REQ-015 Latency with ROUNDS=4, counting from the bgn-sampling edge to the first DONE cycle, both inclusive of strobe cycles:
- Encrypt: 33 strobe cycles (c0 in the first cycle after the edge, c21 in the 33rd).
- Decrypt: 34 strobe cycles.
REQ-016 Counter rules:
- Cleared to 0 in LOAD.
- Incremented by 1 in E_CNT or D_CNT.
- Saturates at 7.
- Holds in all other states, including IDLE and DONE, so the final count stays visible.

Reset
REQ-017 rst=1 at an edge forces IDLE and counter_out=0, from any state including mid-round; all strobes are low in the following cycle.
REQ-018 rst has priority over bgn at the same edge.

Configuration
REQ-019 Macro CU_DECRYPT_EN:
- Defined: the decrypt states and strobes c9..c18 exist.
- Undefined: mode 2'b10 is treated as invalid (FSM holds IDLE) and c9..c18 are tied to 0.
- Encrypt behaviour is identical in both builds.

Structure
REQ-020 The shared package holds:
- the state enum;
- mode constants MODE_ENC=2'b01 and MODE_DEC=2'b10;
- the default ROUNDS value.
REQ-021 The round counter is the sub-module round_counter with ports clk, rst, clr, add and count[2:0].
REQ-022 S-box lookup is excluded from this block; it lives in a separate datapath block.

Verification
REQ-023 Reset then encrypt: rst=1 for 2 cycles, then mode=2'b01 and bgn=1 for one edge -> c0, c1, then the c2..c8 sequence 4 times, then c19, c20, c21; counter_out steps 1..4 on each c5 and ends at 4.
REQ-024 Decrypt (CU_DECRYPT_EN defined): mode=2'b10 and bgn=1 -> c0, c9, (c10..c16)x4, c17, c18, c20, c21, giving 34 strobe cycles.
REQ-025 Invalid mode: mode=2'b11 and bgn=1 for 5 cycles -> all strobes 0 and counter_out unchanged.
REQ-026 Reset mid-run: assert rst in the cycle where c6 is high in round 2 -> next cycle all strobes 0 and counter_out=0; a subsequent run behaves as in REQ-023.
REQ-027 bgn held high: keep bgn=1 through a full encrypt run -> FSM stays in DONE; dropping bgn returns it to IDLE and a new bgn pulse restarts with c0.
REQ-028 One-hot check: on every cycle of every scenario, at most one of c0..c21 is high.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the cipher control unit: FSM state encoding, mode codes, default round count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_unit_pkg;

    // Mode codes presented on cript_or_decript; the other two codes are invalid.
    localparam logic [1:0] MODE_ENC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;

    // Default number of cipher rounds. The legal range is 1..7, which is what fits the 3-bit counter.
    localparam int CU_ROUNDS_DEFAULT = 4;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_LOAD,
        ST_E_XOR,
        ST_E_SAVE,
        ST_E_SUB,
        ST_E_SHIFT,
        ST_E_CNT,
        ST_E_MIX,
        ST_E_KSUB,
        ST_E_KADD,
        ST_E_OUT,
        ST_D_XOR,
        ST_D_SAVE,
        ST_D_SHIFT,
        ST_D_SUB,
        ST_D_CNT,
        ST_D_KSUB,
        ST_D_KADD,
        ST_D_IMIX,
        ST_D_OUT,
        ST_D_FIN,
        ST_WR_DATA,
        ST_WR_KEY,
        ST_DONE
    } state_e;

endpackage

// File: rtl/control_unit_round_counter.sv
// Round counter: synchronous clear, +1 on add, saturating at 7, holds otherwise.
// Latency: count reflects clr/add one cycle after they are sampled.
// Backpressure: none; clr takes priority over add.
//
// Ports: clk, rst (sync active-high), clr, add, count[2:0].
module round_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    output logic [2:0] count
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 3'd0;
        end else if (add && (count_q != 3'd7)) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/control_unit.sv
// Moore FSM sequencing one-hot datapath strobes c0..c21 for an encrypt or decrypt run of ROUNDS rounds.
// Latency: c0 appears the cycle after bgn is sampled; 33 (enc) / 34 (dec) strobe cycles at ROUNDS=4, then DONE.
// Backpressure: none; a run cannot stall, and DONE waits for bgn to drop before re-arming.
//
// Ports: clk, rst (sync active-high), cript_or_decript[1:0] (mode), bgn (level start request),
//        c0..c21 (one-hot strobes), counter_out[2:0] (round count).
// Build option: define CU_DECRYPT_EN to include the decrypt path. Without it, mode 2'b10 is
// treated as invalid and c9..c18 stay low.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int ROUNDS = CU_ROUNDS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cript_or_decript,
    input  logic       bgn,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       c8,
    output logic       c9,
    output logic       c10,
    output logic       c11,
    output logic       c12,
    output logic       c13,
    output logic       c14,
    output logic       c15,
    output logic       c16,
    output logic       c17,
    output logic       c18,
    output logic       c19,
    output logic       c20,
    output logic       c21,
    output logic [2:0] counter_out
);

    state_e state_q;
    state_e state_d;

`ifdef CU_DECRYPT_EN
    // Mode is captured when leaving IDLE so mid-run changes on cript_or_decript have no effect.
    logic dec_q;
    logic dec_d;
`endif

    logic cnt_clr;
    logic cnt_add;
    logic round_done;

    assign round_done = (counter_out == 3'(ROUNDS));

    // The counter is cleared while in LOAD, so it reads 0 from the first XOR state onwards.
    assign cnt_clr = (state_q == ST_LOAD);
`ifdef CU_DECRYPT_EN
    assign cnt_add = (state_q == ST_E_CNT) || (state_q == ST_D_CNT);
`else
    assign cnt_add = (state_q == ST_E_CNT);
`endif

    round_counter u_round_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .add   (cnt_add),
        .count (counter_out)
    );

    always_comb begin
        state_d = state_q;
`ifdef CU_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bgn) begin
                    if (cript_or_decript == MODE_ENC) begin
                        state_d = ST_LOAD;
`ifdef CU_DECRYPT_EN
                        dec_d   = 1'b0;
                    end else if (cript_or_decript == MODE_DEC) begin
                        state_d = ST_LOAD;
                        dec_d   = 1'b1;
`endif
                    end
                end
            end
`ifdef CU_DECRYPT_EN
            ST_LOAD:    state_d = dec_q ? ST_D_XOR : ST_E_XOR;
`else
            ST_LOAD:    state_d = ST_E_XOR;
`endif
            ST_E_XOR:   state_d = ST_E_SAVE;
            ST_E_SAVE:  state_d = ST_E_SUB;
            ST_E_SUB:   state_d = ST_E_SHIFT;
            ST_E_SHIFT: state_d = ST_E_CNT;
            ST_E_CNT:   state_d = ST_E_MIX;
            ST_E_MIX:   state_d = ST_E_KSUB;
            ST_E_KSUB:  state_d = ST_E_KADD;
            ST_E_KADD:  state_d = round_done ? ST_E_OUT : ST_E_SAVE;
            ST_E_OUT:   state_d = ST_WR_DATA;
`ifdef CU_DECRYPT_EN
            ST_D_XOR:   state_d = ST_D_SAVE;
            ST_D_SAVE:  state_d = ST_D_SHIFT;
            ST_D_SHIFT: state_d = ST_D_SUB;
            ST_D_SUB:   state_d = ST_D_CNT;
            ST_D_CNT:   state_d = ST_D_KSUB;
            ST_D_KSUB:  state_d = ST_D_KADD;
            ST_D_KADD:  state_d = ST_D_IMIX;
            ST_D_IMIX:  state_d = round_done ? ST_D_OUT : ST_D_SAVE;
            ST_D_OUT:   state_d = ST_D_FIN;
            ST_D_FIN:   state_d = ST_WR_DATA;
`endif
            ST_WR_DATA: state_d = ST_WR_KEY;
            ST_WR_KEY:  state_d = ST_DONE;
            // A start level left high from the previous run must drop before another run can begin.
            ST_DONE:    state_d = bgn ? ST_DONE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
`ifdef CU_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef CU_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    // Strobes are a pure decode of the state register, so at most one is ever high.
    always_comb begin
        {c21, c20, c19, c18, c17, c16, c15, c14, c13, c12, c11,
         c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0} = '0;
        case (state_q)
            ST_LOAD:    c0  = 1'b1;
            ST_E_XOR:   c1  = 1'b1;
            ST_E_SAVE:  c2  = 1'b1;
            ST_E_SUB:   c3  = 1'b1;
            ST_E_SHIFT: c4  = 1'b1;
            ST_E_CNT:   c5  = 1'b1;
            ST_E_MIX:   c6  = 1'b1;
            ST_E_KSUB:  c7  = 1'b1;
            ST_E_KADD:  c8  = 1'b1;
`ifdef CU_DECRYPT_EN
            ST_D_XOR:   c9  = 1'b1;
            ST_D_SAVE:  c10 = 1'b1;
            ST_D_SHIFT: c11 = 1'b1;
            ST_D_SUB:   c12 = 1'b1;
            ST_D_CNT:   c13 = 1'b1;
            ST_D_KSUB:  c14 = 1'b1;
            ST_D_KADD:  c15 = 1'b1;
            ST_D_IMIX:  c16 = 1'b1;
            ST_D_OUT:   c17 = 1'b1;
            ST_D_FIN:   c18 = 1'b1;
`endif
            ST_E_OUT:   c19 = 1'b1;
            ST_WR_DATA: c20 = 1'b1;
            ST_WR_KEY:  c21 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: expected strobe sequences and round counts come from a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_unit;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       bgn;
    logic c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
    logic c11, c12, c13, c14, c15, c16, c17, c18, c19, c20, c21;
    logic [2:0] counter_out;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    control_unit #(.ROUNDS(R)) dut (
        .clk              (clk),
        .rst              (rst),
        .cript_or_decript (mode),
        .bgn              (bgn),
        .c0 (c0),   .c1 (c1),   .c2 (c2),   .c3 (c3),   .c4 (c4),   .c5 (c5),
        .c6 (c6),   .c7 (c7),   .c8 (c8),   .c9 (c9),   .c10(c10),  .c11(c11),
        .c12(c12),  .c13(c13),  .c14(c14),  .c15(c15),  .c16(c16),  .c17(c17),
        .c18(c18),  .c19(c19),  .c20(c20),  .c21(c21),
        .counter_out      (counter_out)
    );

    function automatic logic [21:0] strobes();
        return {c21, c20, c19, c18, c17, c16, c15, c14, c13, c12, c11,
                c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // -1 when no strobe is high, -2 when more than one is high, else the index of the high strobe.
    function automatic int strobe_idx(logic [21:0] v);
        int n = 0;
        int idx = -1;
        for (int k = 0; k < 22; k++) begin
            if (v[k] === 1'b1) begin
                n++;
                idx = k;
            end
        end
        if (n > 1) return -2;
        return idx;
    endfunction

    // Expected strobe order for one run, straight from the state-sequence description.
    function automatic void build_seq(bit dec);
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(dec ? 9 : 1);
        for (int r = 0; r < R; r++) begin
            for (int s = 0; s < 7; s++) exp_q.push_back(dec ? 10 + s : 2 + s);
        end
        if (dec) begin
            exp_q.push_back(17);
            exp_q.push_back(18);
        end else begin
            exp_q.push_back(19);
        end
        exp_q.push_back(20);
        exp_q.push_back(21);
    endfunction

    // One complete run from IDLE to DONE and back to IDLE.
    // hold_bgn keeps the start level high through DONE; chatter scrambles the mode and bgn mid-run.
    task automatic do_run(input bit dec, input bit hold_bgn, input bit chatter);
        int run_cnt = model_cnt;
        int idx;
        logic [21:0] v;
        build_seq(dec);
        mode = dec ? 2'b10 : 2'b01;
        bgn  = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            v = strobes();
            idx = strobe_idx(v);
            checks++;
            if (idx !== exp_q[i]) begin
                errors++;
                $display("FAIL run_seq dec=%0d step %0d: strobe idx %0d (vec %h), expected %0d",
                         dec, i, idx, v, exp_q[i]);
            end
            if (i > 0) begin
                checks++;
                if (counter_out !== 3'(run_cnt)) begin
                    errors++;
                    $display("FAIL run_cnt dec=%0d step %0d: counter_out %0d, expected %0d",
                             dec, i, counter_out, run_cnt);
                end
            end
            if (i == 0) run_cnt = 0;
            if (exp_q[i] == 5 || exp_q[i] == 13) run_cnt = (run_cnt < 7) ? run_cnt + 1 : 7;
            if (chatter) mode = 2'($urandom);
            if (!hold_bgn) bgn = (i < exp_q.size() - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        model_cnt = run_cnt;
        for (int d = 0; d < (hold_bgn ? 4 : 1); d++) begin
            @(posedge clk); #1;
            checks++;
            if (strobes() !== 22'd0 || counter_out !== 3'(model_cnt)) begin
                errors++;
                $display("FAIL done_state cycle %0d: strobes %h cnt %0d, expected 0 and %0d",
                         d, strobes(), counter_out, model_cnt);
            end
        end
        bgn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (strobes() !== 22'd0 || counter_out !== 3'(model_cnt)) begin
            errors++;
            $display("FAIL back_to_idle: strobes %h cnt %0d, expected 0 and %0d",
                     strobes(), counter_out, model_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bgn = 1'b0; mode = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (strobes() !== 22'd0 || counter_out !== 3'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: strobes %h cnt %0d, expected 0 and 0",
                         i, strobes(), counter_out);
            end
        end
        // rst wins over a valid start request at the same edge.
        bgn = 1'b1; mode = 2'b01;
        @(posedge clk); #1;
        checks++;
        if (strobes() !== 22'd0) begin
            errors++;
            $display("FAIL reset_priority: strobes %h, expected 0", strobes());
        end
        rst = 1'b0; bgn = 1'b0;
        model_cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_encrypt();
        do_run(1'b0, 1'b0, 1'b0);
        do_run(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_decrypt();
`ifdef CU_DECRYPT_EN
        do_run(1'b1, 1'b0, 1'b1);
        do_run(1'b1, 1'b0, 1'b0);
`else
        mode = 2'b10; bgn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (strobes() !== 22'd0 || counter_out !== 3'(model_cnt)) begin
                errors++;
                $display("FAIL dec_disabled cycle %0d: strobes %h cnt %0d, expected 0 and %0d",
                         i, strobes(), counter_out, model_cnt);
            end
        end
        bgn = 1'b0;
`endif
    endtask

    task automatic test_invalid();
        bgn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mode = (i < 5) ? 2'b11 : 2'b00;
            @(posedge clk); #1;
            checks++;
            if (strobes() !== 22'd0 || counter_out !== 3'(model_cnt)) begin
                errors++;
                $display("FAIL invalid_mode cycle %0d: strobes %h cnt %0d, expected 0 and %0d",
                         i, strobes(), counter_out, model_cnt);
            end
        end
        bgn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int n6 = 0;
        bit found = 1'b0;
        mode = 2'b01; bgn = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            bgn = 1'b0;
            if (c6 === 1'b1) begin
                n6++;
                if (n6 == 2) found = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_reach: c6 seen %0d times within 40 cycles, expected 2", n6);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (strobes() !== 22'd0 || counter_out !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: strobes %h cnt %0d, expected 0 and 0", strobes(), counter_out);
        end
        rst = 1'b0;
        model_cnt = 0;
        @(posedge clk); #1;
        do_run(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Start held through DONE: no restart until it drops, then a fresh pulse starts with c0.
        do_run(1'b0, 1'b1, 1'b0);
        do_run(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; bgn = 1'b0; mode = 2'b00;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_invalid();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
